// File: rtl/seg_scan_mux_pkg.sv
// seg_pkg: shared definitions for the seg_scan_mux display driver.
//   - conv_state_e : conversion FSM encoding (IDLE / SHIFT / DONE)
//   - SEG_*        : active-low {a,b,c,d,e,f,g} patterns for 0..9 plus blank
//   - NUM_DIGITS   : number of multiplexed display digits
//   - seg_pattern(): BCD nibble -> segment pattern, blank for 10..15
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = SEG_0;
      4'd1:    p = SEG_1;
      4'd2:    p = SEG_2;
      4'd3:    p = SEG_3;
      4'd4:    p = SEG_4;
      4'd5:    p = SEG_5;
      4'd6:    p = SEG_6;
      4'd7:    p = SEG_7;
      4'd8:    p = SEG_8;
      4'd9:    p = SEG_9;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// seg_scan_mux_if: load handshake and display pins of seg_scan_mux.
//   in_valid / in_value : one-cycle load strobe and binary value (master -> slave)
//   busy                : conversion in progress, loads ignored (slave -> master)
//   seg / dp / anode    : active-low segment, decimal point and digit enables
// The master modport is the producer of values (adder side / bench),
// the slave modport is the display driver.
interface seg_scan_mux_if #(
  parameter int IN_W = 5
);
  import seg_pkg::*;

  logic                  in_valid;
  logic [IN_W-1:0]       in_value;
  logic                  busy;
  logic [6:0]            seg;
  logic                  dp;
  logic [NUM_DIGITS-1:0] anode;

  modport master (
    output in_valid, in_value,
    input  busy, seg, dp, anode
  );

  modport slave (
    input  in_valid, in_value,
    output busy, seg, dp, anode
  );

endinterface

// File: rtl/seg_scan_mux_bin2bcd.sv
// bin2bcd_seq: multi-cycle shift-add-3 binary to BCD converter.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : load strobe, honoured only while idle
//   bin        : IN_W-bit unsigned input
//   busy       : high in SHIFT and DONE
//   done       : high for the single DONE cycle; bcd is final then
//   bcd[15:0]  : four BCD nibbles, nibble 0 = units
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; start loads bin and clears the scratch
// SHIFT | one add-3/shift iteration per cycle, IN_W iterations
// DONE  | scratch holds the result; parent copies it; back to IDLE
module bin2bcd_seq #(
  parameter int IN_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [IN_W-1:0] bin,
  output logic            busy,
  output logic            done,
  output logic [15:0]     bcd
);
  import seg_pkg::*;

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_SHIFT = ST_SHIFT;
  localparam logic [1:0] S_DONE  = ST_DONE;

  // Iteration counter counts down from IN_W-1; zero marks the last shift.
  localparam int CW = $clog2(IN_W + 1);

  logic [1:0]      state;
  logic [15:0]     scratch;
  logic [IN_W-1:0] sreg;
  logic [CW-1:0]   iter_cnt;

  function automatic logic [15:0] add3(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int n = 0; n < 4; n++) begin
      if (v[n*4 +: 4] >= 4'd5) r[n*4 +: 4] = v[n*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      scratch  <= '0;
      sreg     <= '0;
      iter_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sreg     <= bin;
            scratch  <= '0;
            iter_cnt <= CW'(IN_W - 1);
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // The shifted-out top bit is always zero for legal IN_W.
          {scratch, sreg} <= {add3(scratch), sreg} << 1;
          if (iter_cnt == '0) begin
            state <= S_DONE;
          end else begin
            iter_cnt <= iter_cnt - 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign bcd  = scratch;

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: latches a binary result, converts it to BCD with
// bin2bcd_seq and time-multiplexes the digits onto a 4-digit
// common-anode seven-segment display.
//   clk, rst_n   : clock, synchronous active-low reset
//   bus (slave)  : in_valid/in_value load, busy, seg/dp/anode (all active-low)
// Parameters:
//   IN_W        : binary input width, 1..13
//   REFRESH_DIV : clock cycles per digit slot, >= 1
// Build option:
//   SEG_LEADING_ZERO_BLANK_EN : when defined, digits above the most
//   significant nonzero digit are dark; digit 0 always lights.
module seg_scan_mux #(
  parameter int IN_W        = 5,
  parameter int REFRESH_DIV = 100000
) (
  input  logic         clk,
  input  logic         rst_n,
  seg_scan_mux_if.slave bus
);
  import seg_pkg::*;

  localparam int RW = $clog2(REFRESH_DIV + 1);

  logic                  eng_busy;
  logic                  eng_done;
  logic [15:0]           eng_bcd;

  logic [RW-1:0]         refresh_cnt;
  logic [1:0]            idx;
  logic [15:0]           digits;
  logic                  shown_valid;
  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] anode_q;

  logic                  wrap;
  logic [1:0]            idx_nxt;
  logic [15:0]           digits_nxt;
  logic                  shown_nxt;
  logic [NUM_DIGITS-1:0] en_nxt;
  logic [15:0]           digit_shift;
  logic [6:0]            seg_nxt;
  logic [NUM_DIGITS-1:0] anode_nxt;

  bin2bcd_seq #(
    .IN_W (IN_W)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bus.in_valid),
    .bin   (bus.in_value),
    .busy  (eng_busy),
    .done  (eng_done),
    .bcd   (eng_bcd)
  );

  function automatic logic [NUM_DIGITS-1:0] digit_enable(
    input logic [15:0] d,
    input logic        valid
  );
    logic [NUM_DIGITS-1:0] en;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    en[3] = (d[15:12] != 4'd0);
    en[2] = en[3] | (d[11:8] != 4'd0);
    en[1] = en[2] | (d[7:4]  != 4'd0);
    en[0] = 1'b1;
`else
    en = '1;
`endif
    return valid ? en : '0;
  endfunction

  assign wrap = (refresh_cnt == RW'(REFRESH_DIV - 1));

  // Outputs are registered from next-state values so that a new result
  // and a new slot both appear on the very edge that produces them, and
  // seg/anode always move together.
  always_comb begin
    idx_nxt     = wrap ? idx + 2'd1 : idx;
    digits_nxt  = eng_done ? eng_bcd : digits;
    shown_nxt   = shown_valid | eng_done;
    en_nxt      = digit_enable(digits_nxt, shown_nxt);
    digit_shift = digits_nxt >> {idx_nxt, 2'b00};
    seg_nxt     = SEG_BLANK;
    anode_nxt   = '1;
    if (en_nxt[idx_nxt]) begin
      seg_nxt   = seg_pattern(digit_shift[3:0]);
      anode_nxt = ~(NUM_DIGITS'(1) << idx_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      idx         <= '0;
      digits      <= '0;
      shown_valid <= 1'b0;
      seg_q       <= SEG_BLANK;
      anode_q     <= '1;
    end else begin
      refresh_cnt <= wrap ? '0 : refresh_cnt + 1'b1;
      idx         <= idx_nxt;
      digits      <= digits_nxt;
      shown_valid <= shown_nxt;
      seg_q       <= seg_nxt;
      anode_q     <= anode_nxt;
    end
  end

  assign bus.busy  = eng_busy;
  assign bus.seg   = seg_q;
  assign bus.dp    = 1'b1;
  assign bus.anode = anode_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
module tb_seg_scan_mux;

  localparam int IN_W = 5;
  localparam int RDIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  logic [6:0] pat [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0001100};
  int pow10 [0:3] = '{1, 10, 100, 1000};

  seg_scan_mux_if #(.IN_W(IN_W)) bus ();

  seg_scan_mux #(
    .IN_W        (IN_W),
    .REFRESH_DIV (RDIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  // Drive a one-cycle strobe; an accepted load pushes its value.
  task automatic drive_load(input int v);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_value = IN_W'(v);
    if (!bus.busy) exp_q.push_back(v);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("idle_reached", int'(bus.busy), 0);
  endtask

  function automatic bit model_en(input int v, input int k);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    return (k == 0) || (v >= pow10[k]);
`else
    return 1'b1;
`endif
  endfunction

  // Watch one full scan period (4 slots x RDIV cycles) and compare it
  // with the scoreboard's oldest expected value.
  task automatic check_scan();
    int v;
    int cnt [4];
    logic [6:0] sg [4];
    int nblank;
    int ndis;
    int dp_bad;
    logic [6:0] ep;
    chk("sb_depth", exp_q.size(), 1);
    v = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
    nblank = 0;
    dp_bad = 0;
    for (int k = 0; k < 4; k++) begin
      cnt[k] = 0;
      sg[k]  = 7'h7F;
    end
    for (int c = 0; c < 4 * RDIV; c++) begin
      if (bus.dp !== 1'b1) dp_bad++;
      if (bus.anode === 4'hF) nblank++;
      for (int k = 0; k < 4; k++) begin
        if (bus.anode === ~(4'b0001 << k)) begin
          ep = pat[(v / pow10[k]) % 10];
          cnt[k]++;
          if (cnt[k] == 1 || bus.seg !== ep) sg[k] = bus.seg;
        end
      end
      @(negedge clk);
    end
    ndis = 0;
    for (int k = 0; k < 4; k++) begin
      if (model_en(v, k)) begin
        chk($sformatf("v%0d_slot%0d_cnt", v, k), cnt[k], RDIV);
        chk($sformatf("v%0d_slot%0d_seg", v, k), int'(sg[k]),
            int'(pat[(v / pow10[k]) % 10]));
      end else begin
        ndis++;
        chk($sformatf("v%0d_slot%0d_dark", v, k), cnt[k], 0);
      end
    end
    chk($sformatf("v%0d_blank_cnt", v), nblank, ndis * RDIV);
    chk($sformatf("v%0d_dp", v), dp_bad, 0);
  endtask

  initial begin
    int n;
    int nonblank;
    bus.in_valid = 1'b0;
    bus.in_value = '0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_seg", int'(bus.seg), 7'h7F);
    chk("rst_dp", int'(bus.dp), 1);
    chk("rst_anode", int'(bus.anode), 4'hF);
    rst_n = 1'b1;
    nonblank = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.anode !== 4'hF) nonblank++;
    end
    chk("blank_after_rst", nonblank, 0);

    // Load 23 with busy window length
    drive_load(23);
    wait_idle(n);
    chk("busy_len_23", n, IN_W + 1);
    check_scan();

    // Load 0
    drive_load(0);
    wait_idle(n);
    chk("busy_len_0", n, IN_W + 1);
    check_scan();

    // Load 31, then a dropped load of 9 while busy
    drive_load(31);
    @(negedge clk);
    drive_load(9);
    wait_idle(n);
    check_scan();
    repeat (20) @(negedge clk);
    exp_q.push_back(31);
    check_scan();

    // Reset in the middle of a conversion
    drive_load(17);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_anode", int'(bus.anode), 4'hF);
    rst_n = 1'b1;
    exp_q.delete();
    drive_load(5);
    wait_idle(n);
    check_scan();

    // A few more values across the range
    foreach (pow10[i]) begin
      int v;
      v = (i == 0) ? 10 : (i == 1) ? 19 : (i == 2) ? 30 : 7;
      drive_load(v);
      wait_idle(n);
      check_scan();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
